// File: rtl/sort4_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sort4_seq_ctrl
// Purpose  : Sorts four W-bit operands ascending with one shared, stable
//            compare-and-swap unit. The result is published once, with a done pulse.
// Option   : SORT4_EARLY_EXIT_EN enables early completion after a swap-free pass.
// Revision : 1.0 - initial release
// ============================================================================
module sort4_seq_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] ra,
    output logic [W-1:0] rb,
    output logic [W-1:0] rc,
    output logic [W-1:0] rd,
    output logic         busy,
    output logic         done,
    output logic [2:0]   swaps
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_SORT = 1'b1;

    logic [0:0]   r_state;
    logic [0:0]   w_next_state;
    logic [W-1:0] r_w0, r_w1, r_w2, r_w3;
    logic [W-1:0] w_n0, w_n1, w_n2, w_n3;
    logic [2:0]   r_step;
    logic [2:0]   r_sc;
    logic [2:0]   w_sc_next;
    logic         w_swap;
    logic         w_finish;
    logic [W-1:0] r_ra, r_rb, r_rc, r_rd;
    logic [2:0]   r_swaps;
    logic         r_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_SORT;
            c_SORT:  if (w_finish) w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_SORT);
    end

    // Schedule: passes are steps 0-2, 3-4 and 5.
    always_comb begin
        w_n0   = r_w0;
        w_n1   = r_w1;
        w_n2   = r_w2;
        w_n3   = r_w3;
        w_swap = 1'b0;
        case (r_step)
            3'd0, 3'd3, 3'd5: begin
                w_swap = (r_w0 > r_w1);
                if (w_swap) begin
                    w_n0 = r_w1;
                    w_n1 = r_w0;
                end
            end
            3'd1, 3'd4: begin
                w_swap = (r_w1 > r_w2);
                if (w_swap) begin
                    w_n1 = r_w2;
                    w_n2 = r_w1;
                end
            end
            3'd2: begin
                w_swap = (r_w2 > r_w3);
                if (w_swap) begin
                    w_n2 = r_w3;
                    w_n3 = r_w2;
                end
            end
            default: w_swap = 1'b0;
        endcase
        w_sc_next = r_sc + {2'b00, w_swap};
    end

`ifdef SORT4_EARLY_EXIT_EN
    logic r_pass_swap;
    logic w_pass_swap_next;

    always_comb begin
        w_pass_swap_next = ((r_step == 3'd0) || (r_step == 3'd3)) ? w_swap
                                                                  : (r_pass_swap | w_swap);
        w_finish = (r_step == 3'd5) ||
                   (((r_step == 3'd2) || (r_step == 3'd4)) && !w_pass_swap_next);
    end

    always_ff @(posedge clk) begin
        if (rst || (r_state == c_IDLE)) begin
            r_pass_swap <= 1'b0;
        end else begin
            r_pass_swap <= w_pass_swap_next;
        end
    end
`else
    always_comb begin
        w_finish = (r_step == 3'd5);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w0    <= '0;
            r_w1    <= '0;
            r_w2    <= '0;
            r_w3    <= '0;
            r_step  <= 3'd0;
            r_sc    <= 3'd0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_rc    <= '0;
            r_rd    <= '0;
            r_swaps <= 3'd0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_w0   <= a;
                        r_w1   <= b;
                        r_w2   <= c;
                        r_w3   <= d;
                        r_step <= 3'd0;
                        r_sc   <= 3'd0;
                    end
                end
                c_SORT: begin
                    r_w0   <= w_n0;
                    r_w1   <= w_n1;
                    r_w2   <= w_n2;
                    r_w3   <= w_n3;
                    r_sc   <= w_sc_next;
                    r_step <= r_step + 3'd1;
                    if (w_finish) begin
                        r_ra    <= w_n0;
                        r_rb    <= w_n1;
                        r_rc    <= w_n2;
                        r_rd    <= w_n3;
                        r_swaps <= w_sc_next;
                        r_done  <= 1'b1;
                        r_step  <= 3'd0;
                    end
                end
                default: r_step <= 3'd0;
            endcase
        end
    end

    assign ra    = r_ra;
    assign rb    = r_rb;
    assign rc    = r_rc;
    assign rd    = r_rd;
    assign swaps = r_swaps;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sort4_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort4_seq_ctrl
// Purpose  : Scoreboard bench for sort4_seq_ctrl. It checks results, latency,
//            busy, and output hold on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sort4_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0, c = '0, d = '0;
    logic [W-1:0] ra, rb, rc, rd;
    logic         busy, done;
    logic [2:0]   swaps;

    typedef struct {
        logic [W-1:0] r0, r1, r2, r3;
        int           sw;
        int           done_cyc;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    sort4_seq_ctrl #(.W(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a(a), .b(b), .c(c), .d(d),
        .ra(ra), .rb(rb), .rc(rc), .rd(rd),
        .busy(busy), .done(done), .swaps(swaps)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got %0d, want %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic int exp_latency(input logic [W-1:0] x0, x1, x2, x3, input int inv);
`ifdef SORT4_EARLY_EXIT_EN
        logic [W-1:0] x[4];
        logic [W-1:0] t;
        x[0] = x0; x[1] = x1; x[2] = x2; x[3] = x3;
        if (inv == 0) return 3;
        for (int i = 0; i < 3; i++)
            if (x[i] > x[i+1]) begin t = x[i]; x[i] = x[i+1]; x[i+1] = t; end
        if (x[0] <= x[1] && x[1] <= x[2]) return 5;
        return 6;
`else
        return 6 + 0 * (inv + int'(x0) + int'(x1) + int'(x2) + int'(x3));
`endif
    endfunction

    // Drive one start pulse; must be called just after a falling edge.
    task automatic pulse(input logic [W-1:0] va, vb, vc, vd);
        logic [W-1:0] s[4];
        logic [W-1:0] t;
        int           inv;
        exp_t         e;
        a = va; b = vb; c = vc; d = vd;
        start = 1'b1;
        if (q.size() == 0) begin
            s[0] = va; s[1] = vb; s[2] = vc; s[3] = vd;
            inv = 0;
            for (int i = 0; i < 4; i++)
                for (int j = i + 1; j < 4; j++)
                    if (s[i] > s[j]) inv++;
            for (int i = 1; i < 4; i++)
                for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
                    t = s[j]; s[j] = s[j-1]; s[j-1] = t;
                end
            e.r0 = s[0]; e.r1 = s[1]; e.r2 = s[2]; e.r3 = s[3];
            e.sw = inv;
            e.done_cyc = cyc + 1 + exp_latency(va, vb, vc, vd, inv);
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
    endtask

    task automatic wait_done();
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (done) found = 1;
            else @(negedge clk);
        end
        check("done_timeout", int'(found), 1);
    endtask

    // Per-cycle monitor: compares done, busy and the held outputs against the model.
    always @(posedge clk) begin
        bit exp_done;
        #1;
        exp_done = 0;
        if (rst) begin
            q.delete();
            last = '{r0: '0, r1: '0, r2: '0, r3: '0, sw: 0, done_cyc: 0};
        end else if (q.size() > 0 && q[0].done_cyc <= cyc) begin
            if (q[0].done_cyc == cyc) begin
                exp_done = 1;
                last = q[0];
            end
            void'(q.pop_front());
        end
        check("done", int'(done), int'(exp_done));
        check("busy", int'(busy), int'(!rst && q.size() > 0));
        check("ra", int'(ra), int'(last.r0));
        check("rb", int'(rb), int'(last.r1));
        check("rc", int'(rc), int'(last.r2));
        check("rd", int'(rd), int'(last.r3));
        check("swaps", int'(swaps), last.sw);
    end

    initial begin
        last = '{r0: '0, r1: '0, r2: '0, r3: '0, sw: 0, done_cyc: 0};
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        pulse(4'd9, 4'd7, 4'd4, 4'd1);  wait_done();
        repeat (2) @(negedge clk);
        pulse(4'd1, 4'd2, 4'd3, 4'd4);  wait_done();
        @(negedge clk);
        pulse(4'd15, 4'd0, 4'd15, 4'd0); wait_done();
        pulse(4'd5, 4'd5, 4'd5, 4'd5);  wait_done();
        @(negedge clk);

        pulse(4'd3, 4'd1, 4'd2, 4'd0);
        repeat (2) @(negedge clk);
        pulse(4'd8, 4'd8, 4'd8, 4'd8);
        wait_done();
        pulse(4'd2, 4'd0, 4'd3, 4'd1);
        wait_done();
        @(negedge clk);

        pulse(4'd9, 4'd7, 4'd4, 4'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        pulse(4'd6, 4'd2, 4'd8, 4'd1);  wait_done();
        repeat (3) @(negedge clk);

        for (int k = 0; k < 8; k++) begin
            pulse(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_done();
        end
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
